jk_excitation_sequencer: RTL and testbench
==========================================

Name: jk_excitation_sequencer

Overview:
- Drives a bank of JK flip-flops from a stream of target register values.
- Each queued target is converted to per-bit J/K excitation using the JK excitation table. The bank is stepped one clock, then the result is checked against the target.
- This is the inverse of the JK flop: JK flops map J/K to the next state, and this block maps a desired next state to J/K.
- It sits between a target-producing controller and a JK-based register or counter datapath. It exposes J/K for observation and owns the flop bank internally.

Parameters:
- WIDTH, 4, number of JK flops in the bank and width of target data.
- DEPTH, 4, target FIFO entries; power of 2, at least 2.
- DC_TOGGLE, 0, don't-care resolution policy. 0: don't-cares resolve to 0. 1: a state-changing bit uses J=K=1 (toggle).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tgt_valid  in  1  target word offered.
- tgt_ready  out  1  FIFO can accept; a transfer occurs when tgt_valid and tgt_ready are both 1 at a rising edge.
- tgt_data  in  WIDTH  desired next flop-bank value.
- sync_clr  in  1  synchronous clear of the flop bank; overrides J/K.
- j_out  out  WIDTH  J excitation currently applied to the bank.
- k_out  out  WIDTH  K excitation currently applied to the bank.
- q_out  out  WIDTH  flop-bank state.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse: a target has been applied.
- mismatch  out  1  one-cycle pulse, coincident with done, when q_out differs from the applied target.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following take these values immediately.
  - q_out=0, j_out=0, k_out=0, done=0, mismatch=0, busy=0, fifo_count=0, tgt_ready=1.
  - FSM goes to IDLE; FIFO pointers and target register are cleared.
- Reset asserted mid-operation aborts the operation; the in-flight target is discarded.
- FIFO:
  - tgt_ready = (fifo_count != DEPTH).
  - When full, tgt_ready=0 even if a pop occurs in the same cycle; there is no full-bypass.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE: if fifo_count>0, pop the head into the target register and go to DRIVE; otherwise stay.
  - DRIVE: j_out/k_out driven combinationally from the target register and q_out. The flops update at the end of this cycle. Always go to CHECK.
  - CHECK: done=1, and mismatch=(q_out != target). If fifo_count>0, pop and go to DRIVE; otherwise go to IDLE.
- j_out=k_out=0 in every state except DRIVE (hold encoding).
- Excitation per bit i, from current q to target t:
  - 0->0: J=0, K=0.
  - 1->1: J=0, K=0.
  - 0->1: DC_TOGGLE=0 gives J=1, K=0; DC_TOGGLE=1 gives J=1, K=1.
  - 1->0: DC_TOGGLE=0 gives J=0, K=1; DC_TOGGLE=1 gives J=1, K=1.
- Flop update every cycle, per bit:
  - sync_clr=1: q <= 0.
  - Otherwise: J=0,K=0 holds; J=0,K=1 gives 0; J=1,K=0 gives 1; J=1,K=1 toggles.
- Latency: target handshake at edge N → popped at edge N+1 → q_out equals target after edge N+2 → done high in the cycle following edge N+2.
- Steady-state throughput is one target per 2 cycles. A sustained 1-per-cycle input therefore fills the FIFO.
- sync_clr during DRIVE with a nonzero target clears q_out. The following CHECK then asserts mismatch=1. The FSM does not retry.
- busy=1 in DRIVE and CHECK.

Decomposition:
- Shared package jk_pkg holds:
  - the FSM state enum (IDLE/DRIVE/CHECK);
  - the per-bit excitation function excite(q, t, dc_toggle), returning {j, k};
  - the localparam for the fifo_count width.
- Natural sub-module: jk_bit_cell, one JK flop per bit with clk, rst_n, sync_clr, j, k, q. It is instantiated WIDTH times.
- The FIFO stays inline.

Test Plan (WIDTH=4, DEPTH=4):
- Reset, then idle 5 cycles → q_out=0000, tgt_ready=1, busy=0, fifo_count=0, j_out=k_out=0000.
- DC_TOGGLE=0, push 1010 from q=0000 → DRIVE shows j=1010, k=0000. Next cycle done=1, mismatch=0, q_out=1010; total 3 cycles from handshake to done.
- From q=1010, push 0110 → DC_TOGGLE=0 gives j=0100, k=1000; DC_TOGGLE=1 gives j=1100, k=1100. Both give q_out=0110 with mismatch=0.
- Push 8 words (1,2,…,8) back-to-back with tgt_valid held high:
  - tgt_ready drops to 0 when fifo_count=4;
  - all 8 words are applied in order, with done every 2nd cycle;
  - final q_out=1000, no word lost or duplicated.
- Push 1111, assert sync_clr for the DRIVE cycle → q_out=0000, done=1 with mismatch=1. The next target proceeds normally.
- Push 3 words, deassert rst_n during the second DRIVE → all outputs immediately at reset values, fifo_count=0. After release, a new push of 0101 completes with q_out=0101.

Source files
------------

// File: rtl/jk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_pkg                                                               |
// | Shared types and the JK excitation function for the sequencer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package jk_pkg;

  localparam int JK_DEPTH = 4;
  localparam int JK_CNT_W = $clog2(JK_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } jk_state_e;

  // Returns {j, k} that moves a JK flop from q to t.
  function automatic logic [1:0] excite(input logic q, input logic t, input logic dc_toggle);
    logic [1:0] jk;
    jk = 2'b00;
    if (q != t) begin
      if (dc_toggle)
        jk = 2'b11;
      else
        jk = t ? 2'b10 : 2'b01;
    end
    return jk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bit_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_bit_cell                                                          |
// | Single JK flip-flop with synchronous clear and async active-low rst. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jk_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_clr,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (sync_clr) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/jk_excitation_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_excitation_sequencer                                              |
// | Queues target words and drives a JK flop bank to each in turn.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jk_excitation_sequencer
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int DC_TOGGLE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tgt_valid,
  output logic                     tgt_ready,
  input  logic [WIDTH-1:0]         tgt_data,
  input  logic                     sync_clr,
  output logic [WIDTH-1:0]         j_out,
  output logic [WIDTH-1:0]         k_out,
  output logic [WIDTH-1:0]         q_out,
  output logic                     busy,
  output logic                     done,
  output logic                     mismatch,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_tgt;
  jk_state_e        r_state;
  jk_state_e        w_next_state;
  logic             w_push;
  logic             w_pop;
  logic             w_drive;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q;

  // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
  assign tgt_ready  = (r_count != CNT_W'(DEPTH));
  assign w_push     = tgt_valid && tgt_ready;
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= tgt_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tgt    <= '0;
      r_state  <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_tgt    <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_drive      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    mismatch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_next_state = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        busy         = 1'b1;
        w_drive      = 1'b1;
        w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        busy     = 1'b1;
        done     = 1'b1;
        mismatch = (w_q != r_tgt);
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_next_state = ST_DRIVE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outside DRIVE every bit sees J=K=0, so the bank holds.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] w_jk;
    assign w_jk   = excite(w_q[i], r_tgt[i], DC_TOGGLE != 0);
    assign w_j[i] = w_drive & w_jk[1];
    assign w_k[i] = w_drive & w_jk[0];

    jk_bit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_clr (sync_clr),
      .j        (w_j[i]),
      .k        (w_k[i]),
      .q        (w_q[i])
    );
  end

  assign j_out = w_j;
  assign k_out = w_k;
  assign q_out = w_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jk_excitation_sequencer                                           |
// | Table-driven scoreboard bench; two DUTs cover both DC_TOGGLE modes.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jk_excitation_sequencer;

  typedef struct {
    logic [3:0] tgt;
    bit         clr;
    bit         drain;
    bit         lat;
    bit         gap2;
    logic [3:0] j0, k0, j1, k1, q;
    logic       mm;
    int         hs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tgt_valid = 1'b0;
  logic [3:0] tgt_data = 4'd0;
  logic       sync_clr = 1'b0;

  logic       a_ready, a_busy, a_done, a_mm;
  logic [3:0] a_j, a_k, a_q;
  logic [2:0] a_cnt;
  logic       b_ready, b_busy, b_done, b_mm;
  logic [3:0] b_j, b_k, b_q;
  logic [2:0] b_cnt;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_done = 0;
  bit   mon_en = 1'b0;
  bit   saw_full = 1'b0;
  vec_t sbq[$];
  vec_t mon_e;
  vec_t tbl[12];
  vec_t post_rst;

  jk_excitation_sequencer #(.WIDTH(4), .DEPTH(4), .DC_TOGGLE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(a_ready),
    .tgt_data(tgt_data), .sync_clr(sync_clr), .j_out(a_j), .k_out(a_k),
    .q_out(a_q), .busy(a_busy), .done(a_done), .mismatch(a_mm), .fifo_count(a_cnt)
  );

  jk_excitation_sequencer #(.WIDTH(4), .DEPTH(4), .DC_TOGGLE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(b_ready),
    .tgt_data(tgt_data), .sync_clr(sync_clr), .j_out(b_j), .k_out(b_k),
    .q_out(b_q), .busy(b_busy), .done(b_done), .mismatch(b_mm), .fifo_count(b_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] t, input bit cl, input bit dr, input bit la,
                              input bit g2, input logic [3:0] j0, input logic [3:0] k0,
                              input logic [3:0] j1, input logic [3:0] k1,
                              input logic [3:0] q, input logic mm);
    vec_t v;
    v.tgt = t; v.clr = cl; v.drain = dr; v.lat = la; v.gap2 = g2;
    v.j0 = j0; v.k0 = k0; v.j1 = j1; v.k1 = k1; v.q = q; v.mm = mm; v.hs = 0;
    return v;
  endfunction

  // Scoreboard: expectations are popped as each DRIVE/CHECK pair appears.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_vs_count", 32'(a_ready), 32'(a_cnt != 3'd4));
      if (a_cnt == 3'd4) saw_full = 1'b1;
      if (a_busy && !a_done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL drive_unexpected: got DRIVE, required no target in flight");
        end else begin
          chk("j_dc0", 32'(a_j), 32'(sbq[0].j0));
          chk("k_dc0", 32'(a_k), 32'(sbq[0].k0));
          chk("j_dc1", 32'(b_j), 32'(sbq[0].j1));
          chk("k_dc1", 32'(b_k), 32'(sbq[0].k1));
        end
      end else begin
        chk("jk_hold_dc0", 32'({a_j, a_k}), 32'(0));
        chk("jk_hold_dc1", 32'({b_j, b_k}), 32'(0));
      end
      if (a_done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: got done, required no target in flight");
        end else begin
          mon_e = sbq.pop_front();
          chk("done_busy", 32'(a_busy), 32'(1));
          chk("done_dc1", 32'(b_done), 32'(1));
          chk("q_dc0", 32'(a_q), 32'(mon_e.q));
          chk("q_dc1", 32'(b_q), 32'(mon_e.q));
          chk("mismatch_dc0", 32'(a_mm), 32'(mon_e.mm));
          chk("mismatch_dc1", 32'(b_mm), 32'(mon_e.mm));
          if (mon_e.lat) chk("latency", 32'(cyc - mon_e.hs), 32'(2));
          if (mon_e.gap2) chk("done_spacing", 32'(cyc - last_done), 32'(2));
        end
        last_done = cyc;
      end
    end
  end

  task automatic push(input vec_t v);
    int t;
    t = 0;
    @(negedge clk);
    tgt_data  = v.tgt;
    tgt_valid = 1'b1;
    while (!a_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a_ready) begin
      n_chk++;
      $display("FAIL push_timeout: got tgt_ready=0, required 1 within 50 cycles");
    end else begin
      @(posedge clk);
      #1;
      v.hs = cyc;
      sbq.push_back(v);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    tgt_valid = 1'b0;
    do begin
      @(negedge clk);
      t++;
    end while ((sbq.size() != 0 || a_busy) && t < 200);
    if (sbq.size() != 0 || a_busy) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending, required 0 within 200 cycles", sbq.size());
    end
  endtask

  task automatic pulse_clr();
    int t;
    t = 0;
    while (!(a_busy && !a_done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!(a_busy && !a_done)) begin
      n_chk++;
      $display("FAIL clr_timeout: got no DRIVE, required DRIVE within 50 cycles");
    end else begin
      sync_clr = 1'b1;
      @(posedge clk);
      #1;
      sync_clr = 1'b0;
    end
  endtask

  task automatic apply(input vec_t v);
    if (v.drain) wait_idle();
    push(v);
    if (v.clr) begin
      tgt_valid = 1'b0;
      pulse_clr();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_q"}, 32'({a_q, b_q}), 32'(0));
    chk({tag, "_jk"}, 32'({a_j, a_k, b_j, b_k}), 32'(0));
    chk({tag, "_busy"}, 32'({a_busy, b_busy}), 32'(0));
    chk({tag, "_done"}, 32'({a_done, a_mm, b_done, b_mm}), 32'(0));
    chk({tag, "_count"}, 32'({a_cnt, b_cnt}), 32'(0));
    chk({tag, "_ready"}, 32'({a_ready, b_ready}), 32'(2'b11));
  endtask

  initial begin
    int   t;
    bit   seen;
    vec_t rv;

    //           tgt    clr dr lat g2  j0      k0      j1      k1      q       mm
    tbl[0]  = mk(4'hA, 0, 1, 1, 0, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 0);
    tbl[1]  = mk(4'h6, 0, 1, 1, 0, 4'b0100, 4'b1000, 4'b1100, 4'b1100, 4'b0110, 0);
    tbl[2]  = mk(4'h1, 0, 1, 0, 0, 4'b0001, 4'b0110, 4'b0111, 4'b0111, 4'b0001, 0);
    tbl[3]  = mk(4'h2, 0, 0, 0, 1, 4'b0010, 4'b0001, 4'b0011, 4'b0011, 4'b0010, 0);
    tbl[4]  = mk(4'h3, 0, 0, 0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0011, 0);
    tbl[5]  = mk(4'h4, 0, 0, 0, 1, 4'b0100, 4'b0011, 4'b0111, 4'b0111, 4'b0100, 0);
    tbl[6]  = mk(4'h5, 0, 0, 0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0101, 0);
    tbl[7]  = mk(4'h6, 0, 0, 0, 1, 4'b0010, 4'b0001, 4'b0011, 4'b0011, 4'b0110, 0);
    tbl[8]  = mk(4'h7, 0, 0, 0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0111, 0);
    tbl[9]  = mk(4'h8, 0, 0, 0, 1, 4'b1000, 4'b0111, 4'b1111, 4'b1111, 4'b1000, 0);
    tbl[10] = mk(4'hF, 1, 1, 1, 0, 4'b0111, 4'b0000, 4'b0111, 4'b0111, 4'b0000, 1);
    tbl[11] = mk(4'h3, 0, 1, 1, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 0);
    post_rst = mk(4'h5, 0, 1, 1, 0, 4'b0101, 4'b0000, 4'b0101, 4'b0101, 4'b0101, 0);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_reset_state("idle");

    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) apply(tbl[i]);
    wait_idle();
    chk("fifo_reached_full", 32'(saw_full), 32'(1));

    // Abort mid-stream: reset lands in the second DRIVE of a three-word burst.
    mon_en = 1'b0;
    rv = mk(4'hC, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0); push(rv);
    rv.tgt = 4'h3; push(rv);
    rv.tgt = 4'h9; push(rv);
    tgt_valid = 1'b0;
    seen = 1'b0;
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      t++;
      if (a_done) seen = 1'b1;
      else if (seen && a_busy) break;
    end
    chk("reached_second_drive", 32'(seen && a_busy && !a_done), 32'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_count", 32'(a_cnt), 32'(0));
    rst_n = 1'b1;
    sbq.delete();
    mon_en = 1'b1;
    apply(post_rst);
    wait_idle();
    chk("post_rst_q", 32'(a_q), 32'(4'b0101));
    chk("post_rst_count", 32'(a_cnt), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
